// File: rtl/systola_pkg.sv
// Shared definitions for the systolic-array column controllers.
// Holds the column state encoding and default array geometry.
package systola_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      ISSUE = 1'b1
   } col_state_e;

   localparam int ROWS_DEF    = 8;
   localparam int INWIDTH_DEF = 16;

endpackage

// File: rtl/col_input_ctrl.sv
// Column input controller: buffers ROWS operands from the top level, then
// issues them one row per cycle (row 0 first) to give the systolic skew.
module col_input_ctrl
   import systola_pkg::*;
#(
   parameter int ROWS    = ROWS_DEF,
   parameter int INWIDTH = INWIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INWIDTH-1:0] in_w,
   input  logic               wvalid,
   output logic               wready,
   input  logic               pe_stall,
   output logic [INWIDTH-1:0] out_w [0:ROWS-1],
   output logic [0:ROWS-1]    out_v,
   output logic               busy
);

   localparam int            PW   = $clog2(ROWS);
   localparam logic [PW-1:0] LAST = PW'(ROWS - 1);

   col_state_e         r_state;
   col_state_e         w_state_nxt;
   logic [PW-1:0]      r_wcnt;
   logic [PW-1:0]      r_icnt;
   logic [INWIDTH-1:0] r_buf [0:ROWS-1];
   logic               w_xfer;
   logic               w_issue;

   assign w_xfer  = wvalid & wready;
   assign w_issue = (r_state == ISSUE) & ~pe_stall;

   // Pointers are ROWS-sized (power of two), so increment wraps to 0 naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FILL;
         r_wcnt  <= '0;
         r_icnt  <= '0;
         for (int i = 0; i < ROWS; i++) r_buf[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_xfer) begin
            r_buf[r_wcnt] <= in_w;
            r_wcnt        <= r_wcnt + 1'b1;
         end
         if (w_issue) r_icnt <= r_icnt + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      wready      = 1'b0;
      busy        = 1'b0;
      out_v       = '0;
      case (r_state)
         FILL: begin
            wready = 1'b1;
            if (wvalid && (r_wcnt == LAST)) w_state_nxt = ISSUE;
         end
         ISSUE: begin
            busy = 1'b1;
            if (!pe_stall) begin
               out_v[r_icnt] = 1'b1;
               if (r_icnt == LAST) w_state_nxt = FILL;
            end
         end
         default: w_state_nxt = FILL;
      endcase
   end

   always_comb begin
      for (int i = 0; i < ROWS; i++) out_w[i] = r_buf[i];
   end

endmodule

// File: tb/tb_col_input_ctrl.sv
// Scoreboard bench for col_input_ctrl: each accepted word is queued as an
// expected (row, data) issue and matched against out_v/out_w as rows issue.
module tb_col_input_ctrl;

   localparam int ROWS    = 8;
   localparam int INWIDTH = 16;

   logic               clk;
   logic               rst;
   logic [INWIDTH-1:0] in_w;
   logic               wvalid;
   logic               wready;
   logic               pe_stall;
   logic [INWIDTH-1:0] out_w [0:ROWS-1];
   logic [0:ROWS-1]    out_v;
   logic               busy;

   typedef struct {
      int                 row;
      logic [INWIDTH-1:0] data;
   } item_t;

   item_t              sb[$];
   logic [INWIDTH-1:0] exp_buf [0:ROWS-1];
   int                 total = 0;
   int                 bad   = 0;
   int                 cyc;

   col_input_ctrl #(.ROWS(ROWS), .INWIDTH(INWIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_w     (in_w),
      .wvalid   (wvalid),
      .wready   (wready),
      .pe_stall (pe_stall),
      .out_w    (out_w),
      .out_v    (out_v),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Issue monitor: every asserted out_v must be one-hot and match the queue head.
   always @(negedge clk) begin
      int    n;
      int    r;
      item_t e;
      if (!rst) begin
         n = 0;
         r = 0;
         for (int i = 0; i < ROWS; i++) if (out_v[i] === 1'b1) begin n++; r = i; end
         if (n != 0) begin
            if (sb.size() > 0) e = sb.pop_front();
            else e = '{row: -1, data: '0};
            chk("onehot", n, 1);
            chk("row", r, e.row);
            chk("data", 32'(out_w[r]), 32'(e.data));
            chk("iss_wready", 32'(wready), 0);
         end
      end
   end

   task automatic fill(input logic [INWIDTH-1:0] w0, input logic [INWIDTH-1:0] base, input bit gap);
      for (int k = 0; k < ROWS; k++) begin
         chk("fill_wready", 32'(wready), 1);
         chk("fill_busy", 32'(busy), 0);
         wvalid = 1'b1;
         in_w   = (k == 0) ? w0 : base + INWIDTH'(k);
         sb.push_back('{row: k, data: in_w});
         exp_buf[k] = in_w;
         @(posedge clk); #1;
         if (gap && k < ROWS - 1) begin
            wvalid = 1'b0;
            in_w   = 16'hDEAD ^ INWIDTH'(k);
            chk("gap_wready", 32'(wready), 1);
            @(posedge clk); #1;
         end
      end
      wvalid = 1'b0;
      chk("lat_busy", 32'(busy), 1);
      chk("lat_wready", 32'(wready), 0);
   endtask

   // Runs the issue phase; stalls cycles [st, st+len); stops early at abort_at.
   task automatic run_issue(input int st, input int len, input int abort_at, output int n);
      n = 0;
      while (busy && n < 40 && n != abort_at) begin
         pe_stall = (n >= st) && (n < st + len);
         @(posedge clk); #1;
         n++;
      end
      pe_stall = 1'b0;
   endtask

   task automatic end_round(input string tag, input int n, input int exp_len);
      chk(tag, n, exp_len);
      chk("post_wready", 32'(wready), 1);
      chk("post_busy", 32'(busy), 0);
      chk("sb_drain", sb.size(), 0);
      for (int i = 0; i < ROWS; i++) chk("outw", 32'(out_w[i]), 32'(exp_buf[i]));
   endtask

   task automatic chk_reset_state();
      chk("rst_wready", 32'(wready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_outv", 32'(out_v), 0);
      for (int i = 0; i < ROWS; i++) chk("rst_outw", 32'(out_w[i]), 0);
   endtask

   initial begin
      rst      = 1'b1;
      wvalid   = 1'b0;
      in_w     = '0;
      pe_stall = 1'b0;
      for (int i = 0; i < ROWS; i++) exp_buf[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_reset_state();

      // Back-to-back fill 1..8, unstalled issue.
      fill(16'h0001, 16'h0001, 1'b0);
      run_issue(-1, 0, -1, cyc);
      end_round("len_b2b", cyc, ROWS);

      // wvalid toggling: idle cycles carry junk that must not be buffered.
      fill(16'h0031, 16'h0031, 1'b1);
      run_issue(-1, 0, -1, cyc);
      end_round("len_gap", cyc, ROWS);

      // Stall three cycles after row 2 issues.
      fill(16'h0041, 16'h0041, 1'b0);
      run_issue(3, 3, -1, cyc);
      end_round("len_stall", cyc, ROWS + 3);

      // wvalid held with 0xFFFF through ISSUE: ignored, then taken into row 0.
      fill(16'h0051, 16'h0051, 1'b0);
      wvalid = 1'b1;
      in_w   = 16'hFFFF;
      run_issue(-1, 0, -1, cyc);
      end_round("len_wv_hold", cyc, ROWS);
      fill(16'hFFFF, 16'h0060, 1'b0);
      run_issue(-1, 0, -1, cyc);
      end_round("len_ffff", cyc, ROWS);

      // Reset after row 4 issues; pending rows are discarded.
      fill(16'h0071, 16'h0071, 1'b0);
      run_issue(-1, 0, 5, cyc);
      chk("abort_at", cyc, 5);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      for (int i = 0; i < ROWS; i++) exp_buf[i] = '0;
      chk_reset_state();
      fill(16'h0001, 16'h0001, 1'b0);
      run_issue(-1, 0, -1, cyc);
      end_round("len_after_rst", cyc, ROWS);

      // Two consecutive rounds; the second issues only new data.
      fill(16'h0010, 16'h0010, 1'b0);
      run_issue(-1, 0, -1, cyc);
      end_round("len_r1", cyc, ROWS);
      fill(16'h0020, 16'h0020, 1'b0);
      run_issue(-1, 0, -1, cyc);
      end_round("len_r2", cyc, ROWS);

      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
